id_stage_pipelined: RTL and testbench

//  Parametrised decode stage with an integrated ID/EX pipeline register and valid/ready handshakes on both sides.

---
 rtl/id_stage_pipelined_pkg.sv | 147 ++++++++++++++
 rtl/id_stage_pipelined_if.sv | 48 ++++
 rtl/id_stage_pipelined_reg_file.sv | 39 +++
 rtl/id_stage_pipelined.sv | 127 ++++++++++++
 tb/tb_id_stage_pipelined.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pipelined_pkg.sv
// arm_pkg: shared decode definitions for the ID stage.
// Contents:
//   - instruction field positions and status flag positions
//   - mode and condition-code enums
//   - data-processing opcodes and the matching EX command codes
//   - ctrl_t, the control bundle that travels down the pipe
//   - decode_ctrl(): mode/opcode/S bit -> control bundle
//   - cond_passed(): condition field + {N,Z,C,V} -> execute/skip
package arm_pkg;

  // Bit positions inside the 32-bit instruction word
  localparam int COND_LSB = 28;
  localparam int MODE_LSB = 26;
  localparam int I_BIT    = 25;
  localparam int OP_LSB   = 21;
  localparam int S_BIT    = 20;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;
  localparam int RM_LSB   = 0;

  // Flag positions inside status_reg = {N,Z,C,V}
  localparam int STAT_N = 3;
  localparam int STAT_Z = 2;
  localparam int STAT_C = 1;
  localparam int STAT_V = 0;

  typedef enum logic [1:0] {
    MODE_DP   = 2'b00,
    MODE_MEM  = 2'b01,
    MODE_BR   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Data-processing opcodes (instruction bits 24:21)
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Commands understood by the EX stage ALU
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef struct packed {
    logic [3:0] exec_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       branch_taken;
    logic       status_reg_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Anything that is not a recognised instruction decodes to CTRL_NOP,
  // so a garbage word can never write registers or memory.
  function automatic ctrl_t decode_ctrl(input mode_e mode, input logic [3:0] opcode,
                                        input logic s_bit);
    ctrl_t c;
    c = CTRL_NOP;
    case (mode)
      MODE_DP: begin
        c.wb_en         = 1'b1;
        c.status_reg_en = s_bit;
        case (opcode)
          OP_MOV:  c.exec_cmd = EXE_MOV;
          OP_MVN:  c.exec_cmd = EXE_MVN;
          OP_ADD:  c.exec_cmd = EXE_ADD;
          OP_ADC:  c.exec_cmd = EXE_ADC;
          OP_SUB:  c.exec_cmd = EXE_SUB;
          OP_SBC:  c.exec_cmd = EXE_SBC;
          OP_AND:  c.exec_cmd = EXE_AND;
          OP_ORR:  c.exec_cmd = EXE_ORR;
          OP_EOR:  c.exec_cmd = EXE_EOR;
          OP_CMP: begin
            c.exec_cmd = EXE_SUB;
            c.wb_en    = 1'b0;
          end
          OP_TST: begin
            c.exec_cmd = EXE_AND;
            c.wb_en    = 1'b0;
          end
          default: c = CTRL_NOP;
        endcase
      end
      // S selects LDR (1) or STR (0); the address is always base + offset
      MODE_MEM: begin
        c.exec_cmd = EXE_ADD;
        c.mem_r_en = s_bit;
        c.wb_en    = s_bit;
        c.mem_w_en = ~s_bit;
      end
      MODE_BR: c.branch_taken = 1'b1;
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic cond_passed(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v, pass;
    n = status[STAT_N];
    z = status[STAT_Z];
    c = status[STAT_C];
    v = status[STAT_V];
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// id_stage_pipelined_if: the IF/ID -> ID -> EX datapath bundle.
// Signals:
//   upstream:   in_valid, in_ready, pc_in, instruction
//   downstream: out_valid, out_ready, exec_cmd, mem_r_en, mem_w_en,
//               wb_en_out, branch_taken, status_reg_en, val_r_n, val_r_m,
//               imm, shift_operand, signed_imm_24, dest, pc_out
// Modports:
//   master: the surrounding pipeline (drives upstream, consumes downstream)
//   slave:  the ID stage itself
interface id_stage_pipelined_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_A_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  pc_in;
  logic [31:0]        instruction;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         exec_cmd;
  logic               mem_r_en;
  logic               mem_w_en;
  logic               wb_en_out;
  logic               branch_taken;
  logic               status_reg_en;
  logic [DATA_W-1:0]  val_r_n;
  logic [DATA_W-1:0]  val_r_m;
  logic               imm;
  logic [11:0]        shift_operand;
  logic [23:0]        signed_imm_24;
  logic [REG_A_W-1:0] dest;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output in_valid, pc_in, instruction, out_ready,
    input  in_ready, out_valid, exec_cmd, mem_r_en, mem_w_en, wb_en_out,
           branch_taken, status_reg_en, val_r_n, val_r_m, imm, shift_operand,
           signed_imm_24, dest, pc_out
  );

  modport slave (
    input  in_valid, pc_in, instruction, out_ready,
    output in_ready, out_valid, exec_cmd, mem_r_en, mem_w_en, wb_en_out,
           branch_taken, status_reg_en, val_r_n, val_r_m, imm, shift_operand,
           signed_imm_24, dest, pc_out
  );
endinterface

// File: rtl/id_stage_pipelined_reg_file.sv
// id_reg_file: NUM_REGS x DATA_W register file, two read ports, one write port.
// Ports:
//   clk, rst               clock, synchronous active-low reset (clears all entries)
//   wr_en/wr_addr/wr_data  write port, takes effect on the rising edge
//   rd_addr_1/rd_data_1    combinational read port 1
//   rd_addr_2/rd_data_2    combinational read port 2
// A read of the address being written in the same cycle returns wr_data.
module id_reg_file #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int REG_A_W  = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [REG_A_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [REG_A_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0]  rd_data_1,
  input  logic [REG_A_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0]  rd_data_2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: cleared on reset, otherwise written by the WB stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Bypass lets ID see a result that WB is writing this very cycle.
  assign rd_data_1 = (wr_en && (wr_addr == rd_addr_1)) ? wr_data : regs[rd_addr_1];
  assign rd_data_2 = (wr_en && (wr_addr == rd_addr_2)) ? wr_data : regs[rd_addr_2];

endmodule

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: decode stage with its own ID/EX pipeline register.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   bus (slave)                  upstream/downstream handshakes and ID/EX payload
//   status_reg                   {N,Z,C,V} used by the condition check
//   hazard, flush                stall request from the hazard unit, kill from EX
//   wb_en_in, wb_dest, wb_result register-file write port
//   src_1, src_2, two_src        combinational source registers for the hazard unit
module id_stage_pipelined
  import arm_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int REG_A_W  = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  id_stage_pipelined_if.slave bus,
  input  logic [3:0]         status_reg,
  input  logic               hazard,
  input  logic               flush,
  input  logic               wb_en_in,
  input  logic [REG_A_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]  wb_result,
  output logic [REG_A_W-1:0] src_1,
  output logic [REG_A_W-1:0] src_2,
  output logic               two_src
);

  logic              is_str;
  logic              ld;
  ctrl_t             ctrl_dec;
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_out;
  logic              valid_q;
  logic [DATA_W-1:0] rd_data_1, rd_data_2;
  logic [DATA_W-1:0] val_r_n_q, val_r_m_q;
  logic              imm_q;
  logic [11:0]       shift_q;
  logic [23:0]       simm_q;
  logic [REG_A_W-1:0] dest_q;
  logic [ADDR_W-1:0] pc_q;

  // A store reads Rd as the data to write, so it needs Rd on port 2.
  assign is_str  = (bus.instruction[MODE_LSB +: 2] == MODE_MEM) && !bus.instruction[S_BIT];
  assign src_1   = REG_A_W'(bus.instruction[RN_LSB +: 4]);
  assign src_2   = is_str ? REG_A_W'(bus.instruction[RD_LSB +: 4])
                          : REG_A_W'(bus.instruction[RM_LSB +: 4]);
  assign two_src = ~bus.instruction[I_BIT] | is_str;

  // A failed condition keeps the slot but strips its side effects.
  assign ctrl_dec = cond_passed(bus.instruction[COND_LSB +: 4], status_reg)
                  ? decode_ctrl(mode_e'(bus.instruction[MODE_LSB +: 2]),
                                bus.instruction[OP_LSB +: 4], bus.instruction[S_BIT])
                  : CTRL_NOP;

  id_reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_en_in),
    .wr_addr   (wb_dest),
    .wr_data   (wb_result),
    .rd_addr_1 (src_1),
    .rd_data_1 (rd_data_1),
    .rd_addr_2 (src_2),
    .rd_data_2 (rd_data_2)
  );

  // The ID/EX register may take new contents when it is empty or being drained.
  // During a flush the upstream word is accepted only to be thrown away.
  assign ld           = ~valid_q | bus.out_ready;
  assign bus.in_ready = rst & ld & (~hazard | flush);

  // ID/EX pipeline register. Flush wins even while EX is stalled, because
  // the stalled EX side drops the instruction; a hazard only inserts a
  // bubble when the register is free to change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      val_r_n_q <= '0;
      val_r_m_q <= '0;
      imm_q     <= 1'b0;
      shift_q   <= '0;
      simm_q    <= '0;
      dest_q    <= '0;
      pc_q      <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (ld) begin
      if (hazard) begin
        valid_q <= 1'b0;
      end else if (bus.in_valid) begin
        valid_q   <= 1'b1;
        ctrl_q    <= ctrl_dec;
        val_r_n_q <= rd_data_1;
        val_r_m_q <= rd_data_2;
        imm_q     <= bus.instruction[I_BIT];
        shift_q   <= bus.instruction[11:0];
        simm_q    <= bus.instruction[23:0];
        dest_q    <= REG_A_W'(bus.instruction[RD_LSB +: 4]);
        pc_q      <= bus.pc_in;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Bubbles present all-zero control so EX is safe even if it ignores valid.
  assign ctrl_out          = valid_q ? ctrl_q : CTRL_NOP;
  assign bus.out_valid     = valid_q;
  assign bus.exec_cmd      = ctrl_out.exec_cmd;
  assign bus.mem_r_en      = ctrl_out.mem_r_en;
  assign bus.mem_w_en      = ctrl_out.mem_w_en;
  assign bus.wb_en_out     = ctrl_out.wb_en;
  assign bus.branch_taken  = ctrl_out.branch_taken;
  assign bus.status_reg_en = ctrl_out.status_reg_en;
  assign bus.val_r_n       = val_r_n_q;
  assign bus.val_r_m       = val_r_m_q;
  assign bus.imm           = imm_q;
  assign bus.shift_operand = shift_q;
  assign bus.signed_imm_24 = simm_q;
  assign bus.dest          = dest_q;
  assign bus.pc_out        = pc_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed bench with a scoreboard for id_stage_pipelined.
// Accepted instructions push their expected ID/EX contents; each word that
// EX consumes is popped and compared field by field.
module tb_id_stage_pipelined;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int REG_A_W  = 4;

  typedef struct packed {
    logic [3:0]  exec_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        branch_taken;
    logic        status_reg_en;
    logic        imm;
    logic [31:0] val_r_n;
    logic [31:0] val_r_m;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [31:0] pc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         status_reg;
  logic               hazard;
  logic               flush;
  logic               wb_en_in;
  logic [REG_A_W-1:0] wb_dest;
  logic [DATA_W-1:0]  wb_result;
  logic [REG_A_W-1:0] src_1;
  logic [REG_A_W-1:0] src_2;
  logic               two_src;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  exp_t        sb[$];
  logic [31:0] mregs [NUM_REGS];

  always #5 clk = ~clk;

  id_stage_pipelined_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_A_W(REG_A_W)) bus ();

  id_stage_pipelined #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .status_reg (status_reg),
    .hazard     (hazard),
    .flush      (flush),
    .wb_en_in   (wb_en_in),
    .wb_dest    (wb_dest),
    .wb_result  (wb_result),
    .src_1      (src_1),
    .src_2      (src_2),
    .two_src    (two_src)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count = pass_count + 1;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference control: {exec_cmd, mem_r, mem_w, wb, branch, status_en}
  function automatic logic [8:0] modelCtrl(input logic [31:0] ins, input logic [3:0] st);
    logic n, z, cf, v, ok;
    logic [8:0] r;
    {n, z, cf, v} = st;
    case (ins[31:28])
      4'h0: ok = z;          4'h1: ok = ~z;
      4'h2: ok = cf;         4'h3: ok = ~cf;
      4'h4: ok = n;          4'h5: ok = ~n;
      4'h6: ok = v;          4'h7: ok = ~v;
      4'h8: ok = cf & ~z;    4'h9: ok = ~cf | z;
      4'hA: ok = (n == v);   4'hB: ok = (n != v);
      4'hC: ok = ~z & (n == v);
      4'hD: ok = z | (n != v);
      4'hE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    r = '0;
    case (ins[27:26])
      2'b00: case (ins[24:21])
        4'b1101: r = {4'h1, 3'b001, 1'b0, ins[20]};
        4'b1111: r = {4'h9, 3'b001, 1'b0, ins[20]};
        4'b0100: r = {4'h2, 3'b001, 1'b0, ins[20]};
        4'b0101: r = {4'h3, 3'b001, 1'b0, ins[20]};
        4'b0010: r = {4'h4, 3'b001, 1'b0, ins[20]};
        4'b0110: r = {4'h5, 3'b001, 1'b0, ins[20]};
        4'b0000: r = {4'h6, 3'b001, 1'b0, ins[20]};
        4'b1100: r = {4'h7, 3'b001, 1'b0, ins[20]};
        4'b0001: r = {4'h8, 3'b001, 1'b0, ins[20]};
        4'b1010: r = {4'h4, 3'b000, 1'b0, ins[20]};
        4'b1000: r = {4'h6, 3'b000, 1'b0, ins[20]};
        default: r = '0;
      endcase
      2'b01: r = {4'h2, ins[20], ~ins[20], ins[20], 1'b0, 1'b0};
      2'b10: r = {4'h0, 3'b000, 1'b1, 1'b0};
      default: r = '0;
    endcase
    return ok ? r : 9'd0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    if (wb_en_in === 1'b1 && wb_dest == a) return wb_result;
    else return mregs[a];
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid    = v;
    bus.instruction = ins;
    bus.pc_in       = pc;
  endtask

  task automatic wbWrite(input logic en, input logic [3:0] d, input logic [31:0] data);
    wb_en_in  = en;
    wb_dest   = d;
    wb_result = data;
  endtask

  task automatic compareEntry(input exp_t e);
    checkOutput("sb_exec_cmd", 64'(bus.exec_cmd), 64'(e.exec_cmd));
    checkOutput("sb_mem_r_en", 64'(bus.mem_r_en), 64'(e.mem_r_en));
    checkOutput("sb_mem_w_en", 64'(bus.mem_w_en), 64'(e.mem_w_en));
    checkOutput("sb_wb_en_out", 64'(bus.wb_en_out), 64'(e.wb_en));
    checkOutput("sb_branch_taken", 64'(bus.branch_taken), 64'(e.branch_taken));
    checkOutput("sb_status_reg_en", 64'(bus.status_reg_en), 64'(e.status_reg_en));
    checkOutput("sb_imm", 64'(bus.imm), 64'(e.imm));
    checkOutput("sb_val_r_n", 64'(bus.val_r_n), 64'(e.val_r_n));
    checkOutput("sb_val_r_m", 64'(bus.val_r_m), 64'(e.val_r_m));
    checkOutput("sb_shift_operand", 64'(bus.shift_operand), 64'(e.shift_operand));
    checkOutput("sb_signed_imm_24", 64'(bus.signed_imm_24), 64'(e.signed_imm_24));
    checkOutput("sb_dest", 64'(bus.dest), 64'(e.dest));
    checkOutput("sb_pc_out", 64'(bus.pc_out), 64'(e.pc));
  endtask

  // One clock: score handshakes just before the edge, then update the model.
  task automatic tick();
    exp_t e;
    logic [8:0] c;
    logic accept, consume;
    logic [3:0] a2;
    #3;
    accept  = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    consume = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    if (rst !== 1'b1) begin
      sb.delete();
    end else if (flush === 1'b1) begin
      sb.delete();
    end else if (consume) begin
      if (sb.size() == 0) checkOutput("unexpected_output", 64'd1, 64'd0);
      else compareEntry(sb.pop_front());
    end
    if (accept && flush !== 1'b1 && rst === 1'b1) begin
      a2 = (bus.instruction[27:26] == 2'b01 && !bus.instruction[20])
           ? bus.instruction[15:12] : bus.instruction[3:0];
      c = modelCtrl(bus.instruction, status_reg);
      e.exec_cmd      = c[8:5];
      e.mem_r_en      = c[4];
      e.mem_w_en      = c[3];
      e.wb_en         = c[2];
      e.branch_taken  = c[1];
      e.status_reg_en = c[0];
      e.imm           = bus.instruction[25];
      e.val_r_n       = modelRead(bus.instruction[19:16]);
      e.val_r_m       = modelRead(a2);
      e.shift_operand = bus.instruction[11:0];
      e.signed_imm_24 = bus.instruction[23:0];
      e.dest          = bus.instruction[15:12];
      e.pc            = bus.pc_in;
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst !== 1'b1) begin
      foreach (mregs[i]) mregs[i] = '0;
    end else if (wb_en_in === 1'b1) begin
      mregs[wb_dest] = wb_result;
    end
    #1;
  endtask

  logic [31:0] stream [5] = '{32'hE4923008, 32'hEA000010, 32'hF0821003,
                              32'hE0621003, 32'hE1520003};

  initial begin
    rst = 1'b0;
    status_reg = 4'b0000;
    hazard = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    wbWrite(1'b0, 4'd0, 32'h0);
    foreach (mregs[i]) mregs[i] = '0;
    @(posedge clk);
    #1;
    $display("[TB] reset");
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_exec_cmd", 64'(bus.exec_cmd), 64'd0);
    checkOutput("reset_val_r_n", 64'(bus.val_r_n), 64'd0);
    checkOutput("reset_pc_out", 64'(bus.pc_out), 64'd0);
    rst = 1'b1;
    wbWrite(1'b1, 4'd2, 32'd5);
    tick();
    wbWrite(1'b1, 4'd3, 32'd7);
    tick();
    wbWrite(1'b0, 4'd0, 32'h0);

    $display("[TB] ADD R1,R2,R3");
    applyStimulus(1'b1, 32'hE0821003, 32'h100);
    #1;
    checkOutput("add_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("add_src_1", 64'(src_1), 64'd2);
    checkOutput("add_src_2", 64'(src_2), 64'd3);
    checkOutput("add_two_src", 64'(two_src), 64'd1);
    tick();
    checkOutput("add_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("add_exec_cmd", 64'(bus.exec_cmd), 64'd2);
    checkOutput("add_wb_en_out", 64'(bus.wb_en_out), 64'd1);
    checkOutput("add_val_r_n", 64'(bus.val_r_n), 64'd5);
    checkOutput("add_val_r_m", 64'(bus.val_r_m), 64'd7);
    checkOutput("add_dest", 64'(bus.dest), 64'd1);

    $display("[TB] write-to-read bypass");
    applyStimulus(1'b1, 32'hE0845003, 32'h104);
    wbWrite(1'b1, 4'd4, 32'hAA);
    tick();
    wbWrite(1'b0, 4'd0, 32'h0);
    checkOutput("bypass_val_r_n", 64'(bus.val_r_n), 64'hAA);
    applyStimulus(1'b1, 32'hE0846004, 32'h108);
    tick();
    checkOutput("rf_hold_val_r_n", 64'(bus.val_r_n), 64'hAA);
    checkOutput("rf_hold_val_r_m", 64'(bus.val_r_m), 64'hAA);

    $display("[TB] MOVEQ condition");
    applyStimulus(1'b1, 32'h01A07002, 32'h10C);
    tick();
    checkOutput("moveq_z0_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("moveq_z0_exec_cmd", 64'(bus.exec_cmd), 64'd0);
    checkOutput("moveq_z0_wb_en_out", 64'(bus.wb_en_out), 64'd0);
    checkOutput("moveq_z0_pc_out", 64'(bus.pc_out), 64'h10C);
    status_reg = 4'b0100;
    applyStimulus(1'b1, 32'h01A07002, 32'h110);
    tick();
    status_reg = 4'b0000;
    checkOutput("moveq_z1_exec_cmd", 64'(bus.exec_cmd), 64'd1);
    checkOutput("moveq_z1_wb_en_out", 64'(bus.wb_en_out), 64'd1);
    checkOutput("moveq_z1_pc_out", 64'(bus.pc_out), 64'h110);

    $display("[TB] hazard bubbles");
    applyStimulus(1'b1, 32'hE0418002, 32'h114);
    hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("hazard_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      checkOutput("hazard_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("hazard_exec_cmd", 64'(bus.exec_cmd), 64'd0);
    end
    hazard = 1'b0;
    #1;
    checkOutput("hazard_release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkOutput("hazard_issue_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("hazard_issue_pc_out", 64'(bus.pc_out), 64'h114);
    checkOutput("hazard_issue_exec_cmd", 64'(bus.exec_cmd), 64'd4);

    $display("[TB] downstream stall then flush");
    applyStimulus(1'b1, 32'hE1829003, 32'h118);
    tick();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'hE002A003, 32'h11C);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_exec_cmd", 64'(bus.exec_cmd), 64'd7);
      checkOutput("stall_val_r_n", 64'(bus.val_r_n), 64'd5);
      checkOutput("stall_dest", 64'(bus.dest), 64'd9);
      checkOutput("stall_pc_out", 64'(bus.pc_out), 64'h118);
    end
    flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    checkOutput("flush_dropped_out_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] flush while stalled");
    applyStimulus(1'b1, 32'hE1829003, 32'h120);
    tick();
    bus.out_ready = 1'b0;
    flush = 1'b1;
    applyStimulus(1'b1, 32'hE002A003, 32'h124);
    #1;
    checkOutput("flush_stalled_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    checkOutput("flush_stalled_out_valid", 64'(bus.out_valid), 64'd0);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("after_flush_pc_out", 64'(bus.pc_out), 64'h124);
    checkOutput("after_flush_out_valid", 64'(bus.out_valid), 64'd1);

    $display("[TB] STR/LDR/B/NV/undefined/CMP stream");
    applyStimulus(1'b0, 32'h0, 32'h0);
    wbWrite(1'b1, 4'd1, 32'h11);
    tick();
    wbWrite(1'b0, 4'd0, 32'h0);
    applyStimulus(1'b1, 32'hE4821004, 32'h200);
    #1;
    checkOutput("str_src_1", 64'(src_1), 64'd2);
    checkOutput("str_src_2", 64'(src_2), 64'd1);
    checkOutput("str_two_src", 64'(two_src), 64'd1);
    tick();
    checkOutput("str_mem_w_en", 64'(bus.mem_w_en), 64'd1);
    checkOutput("str_val_r_m", 64'(bus.val_r_m), 64'h11);
    foreach (stream[i]) begin
      applyStimulus(1'b1, stream[i], 32'h204 + 32'(i) * 32'd4);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 32'hE0821003, 32'h300);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 32'hE0845003, 32'h304);
    #1;
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_exec_cmd", 64'(bus.exec_cmd), 64'd0);
    checkOutput("midrst_val_r_n", 64'(bus.val_r_n), 64'd0);
    checkOutput("midrst_dest", 64'(bus.dest), 64'd0);
    checkOutput("midrst_pc_out", 64'(bus.pc_out), 64'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 32'hE0845003, 32'h308);
    tick();
    checkOutput("postrst_val_r_n", 64'(bus.val_r_n), 64'd0);
    checkOutput("postrst_val_r_m", 64'(bus.val_r_m), 64'd0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
